// File: rtl/game_pkg.sv
`default_nettype none
//==============================================================================
// Package  : game_pkg
// Brief    : Shared blackjack definitions: deck size, rank/value encoding,
//            dealer FSM states and LFSR constants.
// Revision : 1.0 - initial release
//==============================================================================
package game_pkg;

    localparam int DECK_SIZE = 52;

    localparam logic [3:0] RANK_ACE   = 4'd1;
    localparam logic [3:0] RANK_KING  = 4'd13;
    localparam logic [3:0] ACE_VALUE  = 4'd11;
    localparam logic [3:0] FACE_VALUE = 4'd10;

    localparam int LFSR_WIDTH = 16;
    // Taps 16,14,13,11 of a right-shifting Fibonacci register land on bits 0,2,3,5
    localparam logic [LFSR_WIDTH-1:0] LFSR_TAP_MASK = 16'h002D;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_INIT    = 2'd1,
        ST_SHUFFLE = 2'd2,
        ST_READY   = 2'd3
    } dealerState_t;

    function automatic logic [3:0] rankToValue(input logic [3:0] rank);
        logic [3:0] value;
        if (rank == RANK_ACE)
            value = ACE_VALUE;
        else if ((rank > 4'd10) && (rank <= RANK_KING))
            value = FACE_VALUE;
        else
            value = rank;
        return value;
    endfunction

endpackage
`default_nettype wire

// File: rtl/game_lfsr16.sv
`default_nettype none
//==============================================================================
// Module   : game_lfsr16
// Brief    : 16-bit Fibonacci LFSR with synchronous load; exposes low 6 bits.
// Revision : 1.0 - initial release
//==============================================================================
module game_lfsr16
    import game_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = 16'hACE1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [LFSR_WIDTH-1:0] seed,
    output logic [5:0]            randBits
);

    logic [LFSR_WIDTH-1:0] r_lfsr;
    logic                  w_feedback;

    assign w_feedback = ^(r_lfsr & LFSR_TAP_MASK);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            r_lfsr <= SEED;
        else if (load)
            r_lfsr <= seed;
        else if (enable)
            r_lfsr <= {w_feedback, r_lfsr[LFSR_WIDTH-1:1]};
    end

    assign randBits = r_lfsr[5:0];

endmodule
`default_nettype wire

// File: rtl/game_card_dealer.sv
`default_nettype none
//==============================================================================
// Module   : game_card_dealer
// Brief    : Fisher-Yates shuffled 52-card source with player/Master strobes.
//            Option DEALER_FIXED_SEED_EN: reload SEED at every new game.
// Revision : 1.0 - initial release
//==============================================================================
module game_card_dealer
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       new_Game,
    input  logic       dealReqPlayer,
    input  logic       dealReqMaster,
    output logic [3:0] cardValue4,
    output logic       cardReadyPlayer,
    output logic       cardReadyMaster,
    output logic [5:0] cardsLeft,
    output logic       deckEmpty,
    output logic       busy
);

    localparam logic [5:0] c_DECK_CNT = 6'(DECK_SIZE);
    localparam logic [5:0] c_LAST_IDX = 6'(DECK_SIZE - 1);

    dealerState_t r_state;
    logic [3:0]   r_deck [DECK_SIZE];
    logic [5:0]   r_ptr;
    logic [5:0]   r_idx;
    logic [5:0]   r_cardsLeft;
    logic [3:0]   r_value;
    logic         r_readyPlayer;
    logic         r_readyMaster;
    logic         r_deckEmpty;
    logic         r_busy;

    logic [5:0]   w_rand;
    logic [5:0]   w_j;
    logic         w_lfsrLoad;
    logic         w_deal;

`ifdef DEALER_FIXED_SEED_EN
    assign w_lfsrLoad = (r_state == ST_INIT);
`else
    assign w_lfsrLoad = 1'b0;
`endif

    game_lfsr16 #(
        .SEED(SEED)
    ) u_lfsr (
        .clock   (clock),
        .reset_n (reset_n),
        .enable  (1'b1),
        .load    (w_lfsrLoad),
        .seed    (SEED),
        .randBits(w_rand)
    );

    // Scaled multiply maps a 6-bit random value uniformly-ish onto 0..i
    assign w_j    = 6'(({6'd0, w_rand} * {6'd0, r_idx + 6'd1}) >> 6);
    assign w_deal = dealReqPlayer | dealReqMaster;

    always_ff @(posedge clock) begin
        if (r_state == ST_INIT) begin
            for (int k = 0; k < DECK_SIZE; k++)
                r_deck[k] <= 4'((k / 4) + 1);
        end else if (r_state == ST_SHUFFLE) begin
            r_deck[r_idx] <= r_deck[w_j];
            r_deck[w_j]   <= r_deck[r_idx];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_EMPTY;
            r_ptr         <= c_DECK_CNT;
            r_idx         <= c_LAST_IDX;
            r_cardsLeft   <= 6'd0;
            r_value       <= 4'd0;
            r_readyPlayer <= 1'b0;
            r_readyMaster <= 1'b0;
            r_deckEmpty   <= 1'b1;
            r_busy        <= 1'b0;
        end else begin
            r_readyPlayer <= 1'b0;
            r_readyMaster <= 1'b0;
            if (new_Game) begin
                r_state     <= ST_INIT;
                r_busy      <= 1'b1;
                r_ptr       <= 6'd0;
                r_idx       <= c_LAST_IDX;
                r_cardsLeft <= c_DECK_CNT;
                r_deckEmpty <= 1'b0;
            end else begin
                case (r_state)
                    ST_EMPTY: ;
                    ST_INIT:  r_state <= ST_SHUFFLE;
                    ST_SHUFFLE: begin
                        r_idx <= r_idx - 6'd1;
                        if (r_idx == 6'd1) begin
                            r_state <= ST_READY;
                            r_busy  <= 1'b0;
                        end
                    end
                    ST_READY: begin
                        if (w_deal) begin
                            r_value       <= rankToValue(r_deck[r_ptr]);
                            r_readyPlayer <= dealReqPlayer;
                            r_readyMaster <= ~dealReqPlayer;
                            r_ptr         <= r_ptr + 6'd1;
                            r_cardsLeft   <= r_cardsLeft - 6'd1;
                            if (r_ptr == c_LAST_IDX) begin
                                r_deckEmpty <= 1'b1;
                                r_state     <= ST_EMPTY;
                            end
                        end
                    end
                    default: r_state <= ST_EMPTY;
                endcase
            end
        end
    end

    assign cardValue4      = r_value;
    assign cardReadyPlayer = r_readyPlayer;
    assign cardReadyMaster = r_readyMaster;
    assign cardsLeft       = r_cardsLeft;
    assign deckEmpty       = r_deckEmpty;
    assign busy            = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_game_card_dealer.sv
`default_nettype none
//==============================================================================
// Module   : tb_game_card_dealer
// Brief    : Self-checking bench for game_card_dealer against a deck model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_game_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       new_Game = 1'b0;
    logic       dealReqPlayer = 1'b0;
    logic       dealReqMaster = 1'b0;
    logic [3:0] cardValue4;
    logic       cardReadyPlayer;
    logic       cardReadyMaster;
    logic [5:0] cardsLeft;
    logic       deckEmpty;
    logic       busy;

    int          nChecks = 0;
    int          nErrors = 0;
    logic [15:0] mLfsr;
    int          expVals [52];

    typedef struct {
        logic       rstN;
        logic       reqP;
        logic       reqM;
        logic       expP;
        logic       expM;
        logic [5:0] expLeft;
        logic       expEmpty;
        logic       expBusy;
        logic [3:0] expVal;
    } vec_t;

    vec_t resetVecs [6];

    game_card_dealer #(.SEED(SEED)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .new_Game       (new_Game),
        .dealReqPlayer  (dealReqPlayer),
        .dealReqMaster  (dealReqMaster),
        .cardValue4     (cardValue4),
        .cardReadyPlayer(cardReadyPlayer),
        .cardReadyMaster(cardReadyMaster),
        .cardsLeft      (cardsLeft),
        .deckEmpty      (deckEmpty),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] lfsrNext(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Free-running generator as seen from outside: seed at reset, one step per clock
    always @(posedge clock or negedge reset_n)
        if (!reset_n) mLfsr <= SEED;
        else          mLfsr <= lfsrNext(mLfsr);

    function automatic int blackjackValue(input int rank);
        if (rank == 1)  return 11;
        if (rank >= 11) return 10;
        return rank;
    endfunction

    task automatic buildModel(input logic [15:0] s);
        int          rank [52];
        logic [15:0] l;
        int          j;
        int          t;
        l = s;
        for (int k = 0; k < 52; k++) rank[k] = k / 4 + 1;
        for (int i = 51; i >= 1; i--) begin
            j = (int'(l[5:0]) * (i + 1)) / 64;
            t = rank[i]; rank[i] = rank[j]; rank[j] = t;
            l = lfsrNext(l);
        end
        for (int k = 0; k < 52; k++) expVals[k] = blackjackValue(rank[k]);
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses new_Game, counts busy cycles and strobes seen while busy, then builds the model deck.
    task automatic startGame(input bit holdMaster, output int busyCycles, output int spurious);
        logic [15:0] snap;
        snap          = mLfsr;
        new_Game      = 1'b1;
        dealReqMaster = holdMaster;
        tick();
        new_Game   = 1'b0;
        busyCycles = 0;
        spurious   = 0;
        while (busy && busyCycles < 100) begin
            busyCycles++;
            tick();
            if (busyCycles == 1) snap = mLfsr;
            if (cardReadyPlayer || cardReadyMaster) spurious++;
        end
        dealReqMaster = 1'b0;
`ifdef DEALER_FIXED_SEED_EN
        snap = SEED;
`endif
        buildModel(snap);
    endtask

    task automatic dealTen(input string tag, output int vals [10]);
        int bad;
        bad = 0;
        dealReqPlayer = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            vals[c] = cardReadyPlayer ? int'(cardValue4) : -1;
            if (vals[c] != expVals[c]) bad++;
        end
        dealReqPlayer = 1'b0;
        check({tag, ".modelMismatches"}, bad, 0);
    endtask

    initial begin
        int bc, sp, nStrobe, orderErr, emptyErr, mPtr;
        int cnt [16];
        int seqA [10];
        int seqB [10];
        logic p, m, deal;
        logic [12:0] act, exp;

        // Reset state and requests before any game
        resetVecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'd0};
        resetVecs[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'd0};
        resetVecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'd0};
        resetVecs[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'd0};
        resetVecs[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'd0};
        resetVecs[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 6'd0, 1'b1, 1'b0, 4'd0};
        for (int r = 0; r < 6; r++) begin
            reset_n       = resetVecs[r].rstN;
            dealReqPlayer = resetVecs[r].reqP;
            dealReqMaster = resetVecs[r].reqM;
            tick();
            check($sformatf("vec%0d.readyPlayer", r), cardReadyPlayer, resetVecs[r].expP);
            check($sformatf("vec%0d.readyMaster", r), cardReadyMaster, resetVecs[r].expM);
            check($sformatf("vec%0d.cardsLeft", r), cardsLeft, resetVecs[r].expLeft);
            check($sformatf("vec%0d.deckEmpty", r), deckEmpty, resetVecs[r].expEmpty);
            check($sformatf("vec%0d.busy", r), busy, resetVecs[r].expBusy);
            check($sformatf("vec%0d.cardValue4", r), cardValue4, resetVecs[r].expVal);
        end
        dealReqPlayer = 1'b0;
        dealReqMaster = 1'b0;

        // Master request held through the shuffle is dropped
        startGame(1'b1, bc, sp);
        check("busyDrop.busyCycles", bc, 52);
        check("busyDrop.strobes", sp, 0);
        check("busyDrop.cardsLeft", cardsLeft, 52);
        check("busyDrop.deckEmpty", deckEmpty, 0);

        // Whole deck with the player request held for 53 cycles
        for (int v = 0; v < 16; v++) cnt[v] = 0;
        nStrobe = 0; orderErr = 0; emptyErr = 0; sp = 0;
        dealReqPlayer = 1'b1;
        for (int c = 0; c < 53; c++) begin
            tick();
            if (cardReadyMaster) sp++;
            if (cardReadyPlayer) begin
                if (nStrobe < 52 && int'(cardValue4) != expVals[nStrobe]) orderErr++;
                cnt[cardValue4]++;
                if (deckEmpty != (nStrobe == 51)) emptyErr++;
                nStrobe++;
            end
        end
        dealReqPlayer = 1'b0;
        check("fullDeck.strobes", nStrobe, 52);
        check("fullDeck.orderVsModel", orderErr, 0);
        check("fullDeck.emptyTiming", emptyErr, 0);
        check("fullDeck.masterStrobes", sp, 0);
        check("fullDeck.count11", cnt[11], 4);
        check("fullDeck.count10", cnt[10], 16);
        for (int v = 2; v <= 9; v++) check($sformatf("fullDeck.count%0d", v), cnt[v], 4);
        check("fullDeck.deckEmpty", deckEmpty, 1);
        check("fullDeck.cardsLeft", cardsLeft, 0);
        dealReqMaster = 1'b1;
        tick();
        check("afterEmpty.strobes", {cardReadyPlayer, cardReadyMaster}, 2'b00);
        dealReqMaster = 1'b0;

        // Arbitration: both high, player wins; player then released, Master served
        startGame(1'b0, bc, sp);
        check("arb.busyCycles", bc, 52);
        dealReqPlayer = 1'b1; dealReqMaster = 1'b1;
        tick();
        check("arb1.strobes", {cardReadyPlayer, cardReadyMaster}, 2'b10);
        check("arb1.cardsLeft", cardsLeft, 51);
        check("arb1.value", cardValue4, expVals[0]);
        dealReqPlayer = 1'b0;
        tick();
        check("arb2.strobes", {cardReadyPlayer, cardReadyMaster}, 2'b01);
        check("arb2.cardsLeft", cardsLeft, 50);
        check("arb2.value", cardValue4, expVals[1]);
        dealReqMaster = 1'b0;
        tick();
        check("arb3.strobes", {cardReadyPlayer, cardReadyMaster}, 2'b00);
        check("arb3.valueHeld", cardValue4, expVals[1]);

        // Random requests after a random idle gap, checked cycle by cycle
        repeat ($urandom_range(0, 20)) tick();
        startGame(1'b0, bc, sp);
        check("rand.busyCycles", bc, 52);
        mPtr = 0;
        for (int c = 0; c < 120; c++) begin
            p = ($urandom % 4) == 0;
            m = ($urandom % 2) == 0;
            dealReqPlayer = p; dealReqMaster = m;
            tick();
            deal = (p || m) && mPtr < 52;
            exp  = {deal && p, deal && !p, 6'(52 - mPtr - (deal ? 1 : 0)),
                    (mPtr + (deal ? 1 : 0)) == 52, deal ? 4'(expVals[mPtr]) : 4'd0};
            act  = {cardReadyPlayer, cardReadyMaster, cardsLeft, deckEmpty,
                    deal ? cardValue4 : 4'd0};
            check($sformatf("rand.cycle%0d", c), act, exp);
            if (deal) mPtr++;
        end
        dealReqPlayer = 1'b0; dealReqMaster = 1'b0;

        // Back-to-back games of ten cards each
        startGame(1'b0, bc, sp);
        dealTen("gameA", seqA);
        startGame(1'b0, bc, sp);
        dealTen("gameB", seqB);
`ifdef DEALER_FIXED_SEED_EN
        begin
            int diff;
            diff = 0;
            for (int c = 0; c < 10; c++) if (seqA[c] != seqB[c]) diff++;
            check("determinism.diffs", diff, 0);
        end
`endif

        // Abort at shuffle index 30, then asynchronous reset mid-deal
        new_Game = 1'b1;
        tick();
        new_Game = 1'b0;
        repeat (22) tick();
        check("abort.busyBefore", busy, 1);
        startGame(1'b0, bc, sp);
        check("abort.busyCycles", bc, 52);
        dealReqPlayer = 1'b1;
        tick();
        tick();
        check("abort.secondCard", {cardReadyPlayer, cardValue4}, {1'b1, 4'(expVals[1])});
        #1 reset_n = 1'b0;
        #1;
        check("asyncRst.readyPlayer", cardReadyPlayer, 0);
        check("asyncRst.readyMaster", cardReadyMaster, 0);
        check("asyncRst.cardValue4", cardValue4, 0);
        check("asyncRst.cardsLeft", cardsLeft, 0);
        check("asyncRst.deckEmpty", deckEmpty, 1);
        check("asyncRst.busy", busy, 0);
        dealReqPlayer = 1'b0;
        tick();
        reset_n = 1'b1;
        dealReqPlayer = 1'b1;
        tick();
        check("postRst.strobes", {cardReadyPlayer, cardReadyMaster}, 2'b00);
        dealReqPlayer = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d errors so far", nErrors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
